// File: rtl/adder_pkg.sv
// Shared types and default sizing for the serial adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SLICE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB
// so the top level can derive signed overflow on the final slice.
module adder_slice #(
  parameter int unsigned SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic carry;

  // Ripple the carry LSB to MSB, remembering the carry entering the top bit.
  always_comb begin
    carry = cin;
    c_msb = cin;
    sum   = '0;
    for (int i = 0; i < SLICE; i++) begin
      c_msb  = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor processing SLICE bits per clock, LSB first.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice added per edge, counter 0..NSLICE-1
//   DONE  | result just published, done high for this one cycle
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slc_sum;
  logic             slc_cout;
  logic             slc_cmsb;
  logic [WIDTH-1:0] slc_ext;
  logic [WIDTH-1:0] acc_nxt;

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .sum   (slc_sum),
    .cout  (slc_cout),
    .c_msb (slc_cmsb)
  );

  // New slice enters the accumulator from the top; after NSLICE shifts the
  // first slice has reached bit 0.
  assign slc_ext = WIDTH'(slc_sum);
  assign acc_nxt = (acc_q >> SLICE) | (slc_ext << (WIDTH - SLICE));

  // Next-state and datapath update; subtract stores ~b so the slice only adds.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = acc_nxt;
        carry_d = slc_cout;
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_nxt;
          cout_d  = slc_cout;
          ovf_d   = slc_cout ^ slc_cmsb;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
